// File: rtl/serial_add_sub.sv
// Purpose : digit-serial two's-complement adder/subtractor (DIGIT bits per cycle, LSB first).
// Latency : start sampled at edge k -> done pulses after edge k+N, N = WIDTH/DIGIT.
// Backpr. : start is ignored while busy; a start seen in DONE is taken with no bubble.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, a, b, m  operation request, operands, mode (0 = a+b, 1 = a-b)
//   busy, done      operation in progress / one-cycle result-valid pulse
//   s, c, v, z      result, carry out of MSB, signed overflow, result-is-zero
//
// Optional feature macro: ADDSUB_SAT_EN -- saturate s on signed overflow
// (polarity from the sign of the latched A operand). c and v stay raw.
// Without the macro s wraps modulo 2^WIDTH and no saturation logic exists.

module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working copies: operands shift right one digit per RUN cycle so the
    // slice always sees the next digit in the low bits.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_dig;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT:0]   cy;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] s_fin;
    logic             v_fin;

    // start is only looked at when not busy, i.e. in IDLE or DONE.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_dig = (state == RUN) && (cnt == CNT_W'(N - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // DIGIT-bit ripple slice. cy[i] is the carry into bit i of the slice.
    always_comb begin
        cy      = '0;
        sum_dig = '0;
        cy[0]   = carry;
        for (int i = 0; i < DIGIT; i++) begin
            sum_dig[i] = a_sh[i] ^ b_sh[i] ^ cy[i];
            cy[i+1]    = (a_sh[i] & b_sh[i]) | (cy[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New digit enters from the MSB side; after N shifts the LSB digit has
    // arrived at bit 0 and res_nxt is the complete sum.
    assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));

    // On the last digit cy[DIGIT-1] is the carry into the word MSB.
    assign v_fin = cy[DIGIT] ^ cy[DIGIT-1];

`ifdef ADDSUB_SAT_EN
    // On the last digit a_sh[DIGIT-1] still holds the MSB of the latched A.
    // Overflow only happens when both addends share A's sign, so A's sign
    // tells which rail to clamp to.
    always_comb begin
        s_fin = res_nxt;
        if (v_fin) begin
            if (a_sh[DIGIT-1]) begin
                s_fin = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                s_fin = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    assign s_fin = res_nxt;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_dig) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            c      <= 1'b0;
            v      <= 1'b0;
            z      <= 1'b0;
        end else begin
            if (accept) begin
                // Subtraction is a + ~b + 1: invert B here, the +1 is the carry-in.
                a_sh   <= a;
                b_sh   <= m ? ~b : b;
                carry  <= m;
                res_sh <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                carry  <= cy[DIGIT];
                res_sh <= res_nxt;
                cnt    <= cnt + CNT_W'(1);
                // Visible outputs change only on the edge that enters DONE,
                // so s/c/v/z stay steady for the whole of RUN.
                if (last_dig) begin
                    s <= s_fin;
                    c <= cy[DIGIT];
                    v <= v_fin;
                    z <= ~|s_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c),
        .v     (v),
        .z     (z)
    );

    // Reference: full-width sum, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mm);
        exp_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = mm ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mm};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
`ifdef ADDSUB_SAT_EN
        if (r.v) begin
            r.s = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        r.z  = (r.s == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on every accepted start, pop and compare on every done.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_without_start", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_s", s, e.s);
                    check("sb_c", c, e.c);
                    check("sb_v", v, e.v);
                    check("sb_z", z, e.z);
                end
            end
            if (start && !busy) begin
                sb_q.push_back(model(a, b, m));
            end
        end
    end

    // One operation from IDLE: checks latency, busy length, output hold and done width.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_m);
        int cyc;
        int busy_cyc;
        a = op_a;
        b = op_b;
        m = op_m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        m = 1'($urandom);
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 4 * N) begin
            if (busy) busy_cyc++;
            check("s_hold_run", s, last_exp.s);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, N);
        check("busy_cycles", busy_cyc, N);
        last_exp = model(op_a, op_b, op_m);
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("s_hold_after", s, last_exp.s);
    endtask

    initial begin
        int cyc;
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        m     = 1'b0;
        last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s", s, '0);
        check("rst_c", c, 1'b0);
        check("rst_v", v, 1'b0);
        check("rst_z", z, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain add/subtract patterns, overflow both ways, and zero results.
        run_op(8'h03, 8'h07, 1'b0);
        run_op(8'h03, 8'h07, 1'b1);
        run_op(8'h06, 8'h01, 1'b0);
        run_op(8'h06, 8'h01, 1'b1);
        run_op(8'h73, 8'h17, 1'b0);
        run_op(8'h55, 8'h55, 1'b1);
        run_op(8'h00, 8'h01, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'h80, 8'h80, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h01, 1'b1);
        run_op(8'h80, 8'hFF, 1'b0);

        // start held high: ignored in RUN (operands changed), taken in DONE.
        a = 8'hA5; b = 8'h3C; m = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        a = 8'hC3; b = 8'h5A; m = 1'b1;
        cyc = 0;
        while (!done && cyc < 4 * N) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first_latency", cyc, N);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 4 * N) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_second_latency", cyc, N);
        last_exp = model(8'hC3, 8'h5A, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of an operation: outputs clear at once, no done follows.
        a = 8'h12; b = 8'h34; m = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_s", s, '0);
        check("midrst_c", c, 1'b0);
        check("midrst_v", v, 1'b0);
        check("midrst_z", z, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        last_exp = '0;
        seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_done_after_rst", seen, 0);

        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h40, 8'h40, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
